mips_instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the pipelined MIPS core. It performs the inverse of the control decoder: it accepts symbolic operation records over a valid/ready stream and encodes each into a 32-bit MIPS word. It writes the words sequentially into instruction memory and resolves branch offsets and jump indices from word-address targets. It is used by the boot/self-test path to build programs in IMEM before the core is released from reset.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mips_instr_pack.sv | 52 +++++
 rtl/mips_instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encoder/decoder definitions: op enum, opcode/funct values, error and FSM state types.
// ENC_HALT_EN adds the HALT state used to append a self-loop halt word.
package mips_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
    OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_JR   = 5'd10, OP_ADDI = 5'd11,
    OP_ORI  = 5'd12, OP_XORI = 5'd13, OP_LUI  = 5'd14, OP_LW   = 5'd15,
    OP_SW   = 5'd16, OP_BEQ  = 5'd17, OP_BNE  = 5'd18, OP_J    = 5'd19,
    OP_JAL  = 5'd20
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_BADOP = 2'd1,
    ERR_FULL  = 2'd2
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR  = 3'd3
`ifdef ENC_HALT_EN
    , ST_HALT = 3'd4
`endif
  } state_e;

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational encoder: one symbolic op plus its fields and write address -> 32-bit MIPS word.
module mips_instr_pack
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [4:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [15:0]       imm_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [31:0]       word_o,
  output logic              bad_op_o
);

  // Low 16 bits of the 17-bit signed difference target - (pc + 1).
  logic [15:0] br_off;
  assign br_off = 16'(target_i) - 16'(pc_i) - 16'd1;

  always_comb begin
    word_o   = 32'h0;
    bad_op_o = 1'b0;
    case (op_i)
      OP_NOP:  word_o = 32'h0;
      OP_ADD:  word_o = enc_r(rs_i, rt_i, rd_i, shamt_i, FUNCT_ADD);
      OP_SUB:  word_o = enc_r(rs_i, rt_i, rd_i, shamt_i, FUNCT_SUB);
      OP_AND:  word_o = enc_r(rs_i, rt_i, rd_i, shamt_i, FUNCT_AND);
      OP_OR:   word_o = enc_r(rs_i, rt_i, rd_i, shamt_i, FUNCT_OR);
      OP_XOR:  word_o = enc_r(rs_i, rt_i, rd_i, shamt_i, FUNCT_XOR);
      OP_SLT:  word_o = enc_r(rs_i, rt_i, rd_i, shamt_i, FUNCT_SLT);
      OP_SLL:  word_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FUNCT_SLL);
      OP_SRL:  word_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FUNCT_SRL);
      OP_SRA:  word_o = enc_r(5'd0, rt_i, rd_i, shamt_i, FUNCT_SRA);
      OP_JR:   word_o = {OPC_RTYPE, rs_i, 15'd0, FUNCT_JR};
      OP_ADDI: word_o = enc_i(OPC_ADDI, rs_i, rt_i, imm_i);
      OP_ORI:  word_o = enc_i(OPC_ORI,  rs_i, rt_i, imm_i);
      OP_XORI: word_o = enc_i(OPC_XORI, rs_i, rt_i, imm_i);
      OP_LUI:  word_o = enc_i(OPC_LUI,  5'd0, rt_i, imm_i);
      OP_LW:   word_o = enc_i(OPC_LW,   rs_i, rt_i, imm_i);
      OP_SW:   word_o = enc_i(OPC_SW,   rs_i, rt_i, imm_i);
      OP_BEQ:  word_o = enc_i(OPC_BEQ,  rs_i, rt_i, br_off);
      OP_BNE:  word_o = enc_i(OPC_BNE,  rs_i, rt_i, br_off);
      OP_J:    word_o = {OPC_J,   26'(target_i)};
      OP_JAL:  word_o = {OPC_JAL, 26'(target_i)};
      default: bad_op_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams op records into IMEM as encoded MIPS words with pointer, count and error tracking.
// Define ENC_HALT_EN to append a self-loop J halt word after the last op.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_e              err_code_q, err_code_d;

  logic [31:0] pack_word;
  logic        bad_op;
  logic        ptr_full;

  mips_instr_pack #(.ADDR_W(ADDR_W)) u_pack (
    .op_i     (in_op),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .imm_i    (in_imm),
    .target_i (in_target),
    .pc_i     (wr_ptr_q),
    .word_o   (pack_word),
    .bad_op_o (bad_op)
  );

  assign ptr_full = &wr_ptr_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;

    if (start) begin
      state_d    = ST_RUN;
      wr_ptr_d   = '0;
      count_d    = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = ERR_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (in_valid) begin
            if (bad_op) begin
              state_d    = ST_ERR;
              error_d    = 1'b1;
              err_code_d = ERR_BADOP;
            end else begin
              we_d     = 1'b1;
              addr_d   = wr_ptr_q;
              wdata_d  = pack_word;
              wr_ptr_d = wr_ptr_q + ADDR_W'(1);
              count_d  = count_q + (ADDR_W+1)'(1);
              if (in_last) begin
`ifdef ENC_HALT_EN
                // No slot left for the halt word after the last address.
                if (ptr_full) begin
                  state_d    = ST_ERR;
                  error_d    = 1'b1;
                  err_code_d = ERR_FULL;
                end else begin
                  state_d = ST_HALT;
                end
`else
                state_d = ST_DONE;
                done_d  = 1'b1;
`endif
              end else if (ptr_full) begin
                state_d    = ST_ERR;
                error_d    = 1'b1;
                err_code_d = ERR_FULL;
              end
            end
          end
        end
`ifdef ENC_HALT_EN
        ST_HALT: begin
          we_d     = 1'b1;
          addr_d   = wr_ptr_q;
          wdata_d  = {OPC_J, 26'(wr_ptr_q)};
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          count_d  = count_q + (ADDR_W+1)'(1);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign in_ready   = (state_q == ST_RUN);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign count      = count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized scoreboard bench for mips_instr_encoder with a field-arithmetic reference encoder.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready, in_last;
  logic [4:0]        in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]       in_imm;
  logic [ADDR_W-1:0] in_target;
  logic              imem_we, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;

  mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .error(error), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int       addr;
    bit [31:0] word;
    int       cnt;
    bit       dn;
  } wr_t;
  wr_t exp_q[$];

  // Behavioural model of the loader state
  bit m_run, m_done, m_err;
  int m_code, m_ptr, m_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit [31:0] ref_word(int op, int rs, int rt, int rd, int sh,
                                         int imm, int tgt, int pc);
    int rfun[9] = '{32, 34, 36, 37, 38, 42, 0, 2, 3};
    int iopc[6] = '{8, 13, 14, 15, 35, 43};
    bit [31:0] b_rs = rs, b_rt = rt, b_rd = rd, b_sh = sh, b_imm = imm & 16'hFFFF;
    bit [31:0] b_opc, b_off;
    if (op == 0) return 32'h0;
    if (op <= 9) begin
      if (op >= 7) b_rs = 0;
      return (b_rs << 21) | (b_rt << 16) | (b_rd << 11) | (b_sh << 6) | rfun[op-1];
    end
    if (op == 10) return (b_rs << 21) | 32'd8;
    if (op <= 16) begin
      b_opc = iopc[op-11];
      if (op == 14) b_rs = 0;
      return (b_opc << 26) | (b_rs << 21) | (b_rt << 16) | b_imm;
    end
    if (op <= 18) begin
      b_opc = (op == 17) ? 4 : 5;
      b_off = (tgt - (pc + 1)) & 32'hFFFF;
      return (b_opc << 26) | (b_rs << 21) | (b_rt << 16) | b_off;
    end
    b_opc = op - 17;
    return (b_opc << 26) | tgt;
  endfunction

  task automatic model_accept(int op, int rs, int rt, int rd, int sh, int imm, int tgt, bit last);
    bit full;
    bit dn_now;
    if (op > 20) begin
      m_run = 0; m_err = 1; m_code = 1;
      return;
    end
    full = (m_ptr == DEPTH - 1);
`ifdef ENC_HALT_EN
    dn_now = 0;
`else
    dn_now = last;
`endif
    exp_q.push_back('{m_ptr, ref_word(op, rs, rt, rd, sh, imm, tgt, m_ptr), m_cnt + 1, dn_now});
    m_cnt++;
    m_ptr++;
    if (last) begin
      m_run = 0;
`ifdef ENC_HALT_EN
      if (full) begin
        m_err = 1; m_code = 2;
      end else begin
        exp_q.push_back('{m_ptr, (32'd2 << 26) | m_ptr, m_cnt + 1, 1'b1});
        m_cnt++;
        m_ptr++;
        m_done = 1;
      end
`else
      m_done = 1;
`endif
    end else if (full) begin
      m_run = 0; m_err = 1; m_code = 2;
    end
  endtask

  task automatic send(int op, int rs, int rt, int rd, int sh, int imm, int tgt, bit last);
    @(negedge clk);
    check("in_ready", in_ready, m_run);
    in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_last = last;
    if (m_run) model_accept(op, rs, rt, rd, sh, imm, tgt, last);
  endtask

  task automatic send_rand(bit last);
    send($urandom_range(0, 20), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
         $urandom_range(0, DEPTH - 1), last);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    m_run = 1; m_done = 0; m_err = 0; m_code = 0; m_ptr = 0; m_cnt = 0;
    @(negedge clk);
    start = 0; in_valid = 0;
    check("start_count", count, 0);
    check("start_error", error, 0);
    check("start_ready", in_ready, 1);
  endtask

  task automatic settle_status(input string tag);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    check({tag, "_done"}, done, m_done);
    check({tag, "_error"}, error, m_err);
    check({tag, "_err_code"}, err_code, m_code);
    check({tag, "_count"}, count, m_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_count"}, count, 0);
  endtask

  // Monitor: every IMEM write must match the oldest expected record
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %08h with no write expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.word);
        check("wr_count", count, e.cnt);
        check("wr_done", done, e.dn);
        $display("write addr=%0d data=%08h count=%0d done=%0b", imem_addr, imem_wdata, count, done);
      end
    end
  end

  initial begin
    rst = 1; start = 0; in_valid = 0; in_last = 0;
    in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_shamt = 0; in_imm = 0; in_target = 0;
    m_run = 0; m_done = 0; m_err = 0; m_code = 0; m_ptr = 0; m_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // Directed program with known encodings
    pulse_start();
    send(1, 1, 2, 3, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    check("add_word", imem_wdata, 32'h00221820);
    check("add_count", count, 1);
    send(14, 7, 5, 9, 1, 16'h1234, 0, 0);
    send(17, 1, 2, 0, 0, 16'h5555, 0, 0);
    @(negedge clk);
    in_valid = 0;
    check("beq_word", imem_wdata, 32'h1022FFFD);
    send(7, 9, 3, 2, 4, 0, 0, 0);
    send(20, 0, 0, 0, 0, 0, 8'h10, 1);
    @(negedge clk);
    in_valid = 0;
    check("jal_word", imem_wdata, 32'h0C000010);
`ifdef ENC_HALT_EN
    check("jal_done_early", done, 0);
    @(negedge clk);
    check("halt_word", imem_wdata, 32'h08000005);
    check("halt_done", done, 1);
`else
    check("jal_done", done, 1);
`endif
    settle_status("prog1");

    // Illegal op: no write, sticky error, not ready
    pulse_start();
    send(2, 4, 5, 6, 0, 0, 0, 0);
    send(31, 1, 1, 1, 1, 1, 1, 0);
    @(negedge clk);
    in_valid = 0;
    check("badop_error", error, 1);
    check("badop_code", err_code, 1);
    check("badop_ready", in_ready, 0);
    send(1, 1, 1, 1, 0, 0, 0, 0);
    settle_status("badop");

    // start during RUN takes priority over the same-cycle op
    pulse_start();
    for (int i = 0; i < 5; i++) send_rand(0);
    pulse_start();
    send(4, 3, 4, 5, 0, 0, 0, 0);
    settle_status("restart");

    // rst mid-stream
    pulse_start();
    for (int i = 0; i < 4; i++) send_rand(0);
    @(negedge clk);
    rst = 1;
    m_run = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 0; in_valid = 0;
    m_done = 0; m_err = 0; m_code = 0; m_cnt = 0;
    settle_status("midrst");

    // Fill memory without in_last -> FULL, then with in_last on the final slot
    for (int run = 0; run < 2; run++) begin
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          in_valid = 0;
        end
        send_rand((run == 1) && (i == DEPTH - 1));
      end
      send_rand(0);
      settle_status(run == 0 ? "fill_full" : "fill_last");
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
